uart_io_tx: RTL



---
 rtl/uart_io_tx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_io_tx.sv
// uart_io_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO.
//
// Ports:
//   clock     system clock; every register updates on its rising edge
//   reset     synchronous active-high reset; aborts any frame and flushes the FIFO
//   io_wen    one-cycle write strobe from the CPU IO decode
//   io_wdata  byte to enqueue
//   ovf_clr   one-cycle strobe that clears the sticky overflow flag
//   tx        serial output, idle high
//   busy      high while a frame (START/DATA/STOP) is being shifted
//   full      FIFO holds 2^FIFO_AW bytes
//   empty     FIFO holds no bytes
//   count     current FIFO occupancy
//   overflow  sticky: a write was dropped because the FIFO was full
//   tx_done   one-cycle pulse after the last cycle of each stop bit
module uart_io_tx #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int FIFO_AW      = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_wen,
  input  logic [7:0]         io_wdata,
  input  logic               ovf_clr,
  output logic               tx,
  output logic               busy,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count,
  output logic               overflow,
  output logic               tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1'b1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1'b1);
  localparam logic [FIFO_AW:0]   OCC_ONE  = (FIFO_AW + 1)'(1'b1);
  localparam logic [FIFO_AW:0]   DEPTH    = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_r;
  logic [7:0]         mem_r [0:(1 << FIFO_AW) - 1];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic               overflow_r;
  logic [CW-1:0]      baud_cnt_r;
  logic [2:0]         bit_idx_r;
  logic [7:0]         shift_r;
  logic               tx_r;
  logic               busy_r;
  logic               tx_done_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic drop_s;

  // FIFO flags and handshake terms, all from registered state.
  always_comb begin
    full_s  = (count_r == DEPTH);
    empty_s = (count_r == {(FIFO_AW + 1){1'b0}});
    push_s  = io_wen & ~full_s;
    // A write while full is dropped even if a pop frees a slot on the same edge.
    drop_s  = io_wen & full_s;
    pop_s   = (state_r == IDLE) & ~empty_s;
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= io_wdata;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r   <= {FIFO_AW{1'b0}};
      rd_ptr_r   <= {FIFO_AW{1'b0}};
      count_r    <= {(FIFO_AW + 1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + OCC_ONE;
        2'b01:   count_r <= count_r - OCC_ONE;
        default: count_r <= count_r;
      endcase
      // Setting wins over clearing when both happen on one edge.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Transmit state machine with registered tx, busy and tx_done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= {CW{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            shift_r    <= mem_r[rd_ptr_r];
            baud_cnt_r <= {CW{1'b0}};
            state_r    <= START;
            tx_r       <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        START: begin
          if (baud_cnt_r == CNT_LAST) begin
            baud_cnt_r <= {CW{1'b0}};
            bit_idx_r  <= 3'd0;
            state_r    <= DATA;
            tx_r       <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (baud_cnt_r == CNT_LAST) begin
            baud_cnt_r <= {CW{1'b0}};
            shift_r    <= {1'b0, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              // Next bit is shift[1] because the shift lands on this same edge.
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (baud_cnt_r == CNT_LAST) begin
            baud_cnt_r <= {CW{1'b0}};
            tx_done_r  <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= {CW{1'b0}};
          tx_r       <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = tx_r;
  assign busy     = busy_r;
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_r;
  assign overflow = overflow_r;
  assign tx_done  = tx_done_r;

endmodule
